// File: rtl/aes_pipe_scheduler.sv
// Round-robin scheduler that shares one fixed-latency AES-128 pipeline among NREQ requesters,
// tracks block ownership through a tag pipe and sequences key expansion around pipeline drains.
module aes_pipe_scheduler #(
  parameter int NREQ       = 4,
  parameter int LAT        = 11,
  parameter int FIFO_DEPTH = 16,
  localparam int IDW       = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*128-1:0]   req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  rekey,
  output logic                  kexp_start,
  input  logic                  kexp_ready,
  output logic [127:0]          pipe_data,
  output logic                  pipe_valid,
  input  logic [127:0]          pipe_out,
  input  logic                  pipe_done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [127:0]          rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy,
  output logic                  err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYEXP,
    S_KWAIT,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t           state_q, state_nxt;
  logic             kwait_first_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   grant_id;
  logic [IDW:0]     arb_sum;
  logic             grant_found;
  logic             issue;

  logic [CW-1:0]    in_flight_q, in_flight_nxt;
  logic [CW-1:0]    fifo_count_q, fifo_count_nxt, count_after_pop;
  logic [CW:0]      credit_used;
  logic             done_dec;

  logic             pipe_vld_p0;
  logic [IDW-1:0]   pipe_id_p0;
  logic [127:0]     pipe_data_p0;
  logic [LAT-1:0]   tag_vld_p1;
  logic [IDW-1:0]   tag_id_p1 [LAT];
  logic             tail_vld;
  logic [IDW-1:0]   tail_id;

  logic [127:0]     mem_data [FIFO_DEPTH];
  logic [IDW-1:0]   mem_id   [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic             fifo_full, pop, push, err_set;
  logic [127:0]     head_data;
  logic [IDW-1:0]   head_id;

  logic             rsp_valid_q;
  logic [127:0]     rsp_data_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             busy_q, err_q;

  // Round-robin arbitration starting at rr_ptr_q
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    arb_sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      arb_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (arb_sum >= (IDW+1)'(NREQ)) arb_sum = arb_sum - (IDW+1)'(NREQ);
      if (!grant_found && req_valid[arb_sum[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = arb_sum[IDW-1:0];
      end
    end
  end

  // Credits count both in-flight blocks and queued responses so the FIFO can never overflow.
  assign credit_used = {1'b0, in_flight_q} + {1'b0, fifo_count_q};
  assign issue       = (state_q == S_RUN) && kexp_ready && grant_found &&
                       (credit_used < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[grant_id] = 1'b1;
  end

  assign done_dec      = pipe_done && (in_flight_q != '0);
  assign in_flight_nxt = in_flight_q + CW'(issue) - CW'(done_dec);

  always_comb begin
    state_nxt  = state_q;
    kexp_start = 1'b0;
    case (state_q)
      S_IDLE:   if (rekey) state_nxt = S_KEYEXP;
      S_KEYEXP: begin
        kexp_start = 1'b1;
        state_nxt  = S_KWAIT;
      end
      // kexp_ready may still reflect the previous key on the first KWAIT cycle
      S_KWAIT:  if (!kwait_first_q && kexp_ready) state_nxt = S_RUN;
      S_RUN:    if (rekey) state_nxt = S_DRAIN;
      S_DRAIN:  if (in_flight_nxt == '0) state_nxt = S_KEYEXP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      kwait_first_q <= 1'b0;
      rr_ptr_q      <= '0;
      in_flight_q   <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      kwait_first_q <= (state_q == S_KEYEXP);
      in_flight_q   <= in_flight_nxt;
      // busy is registered so that every output reads 0 while reset is held
      busy_q        <= (state_nxt != S_RUN) || (in_flight_nxt != '0);
      err_q         <= err_q | err_set;
      if (issue) rr_ptr_q <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  // Stage p0: issue register feeding the datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld_p0  <= 1'b0;
      pipe_id_p0   <= '0;
      pipe_data_p0 <= '0;
    end else begin
      pipe_vld_p0 <= issue;
      if (issue) begin
        pipe_id_p0   <= grant_id;
        pipe_data_p0 <= req_data[{grant_id, 7'b0} +: 128];
      end
    end
  end

  // Stage p1: LAT-deep tag pipe; its tail lines up with pipe_done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld_p1 <= '0;
      for (int k = 0; k < LAT; k++) tag_id_p1[k] <= '0;
    end else begin
      tag_vld_p1[0] <= pipe_vld_p0;
      tag_id_p1[0]  <= pipe_id_p0;
      for (int k = 1; k < LAT; k++) begin
        tag_vld_p1[k] <= tag_vld_p1[k-1];
        tag_id_p1[k]  <= tag_id_p1[k-1];
      end
    end
  end

  assign tail_vld = tag_vld_p1[LAT-1];
  assign tail_id  = tag_id_p1[LAT-1];

  assign pop             = rsp_valid_q && rsp_ready;
  assign fifo_full       = (fifo_count_q == CW'(FIFO_DEPTH));
  assign push            = pipe_done && tail_vld && (!fifo_full || pop);
  assign err_set         = pipe_done && (!tail_vld || (fifo_full && !pop));
  assign count_after_pop = fifo_count_q - CW'(pop);
  assign fifo_count_nxt  = count_after_pop + CW'(push);
  assign rd_ptr_nxt      = rd_ptr_q + AW'(pop);

  // The entry being pushed becomes the head when the FIFO would otherwise be empty.
  always_comb begin
    head_data = mem_data[rd_ptr_nxt];
    head_id   = mem_id[rd_ptr_nxt];
    if (push && (count_after_pop == '0)) begin
      head_data = pipe_out;
      head_id   = tail_id;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= pipe_out;
      mem_id[wr_ptr_q]   <= tail_id;
    end
  end

  // Stage p2: registered response head
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_q + AW'(push);
      rd_ptr_q     <= rd_ptr_nxt;
      fifo_count_q <= fifo_count_nxt;
      rsp_valid_q  <= (fifo_count_nxt != '0);
      if (fifo_count_nxt != '0) begin
        rsp_data_q <= head_data;
        rsp_id_q   <= head_id;
      end
    end
  end

  assign pipe_valid = pipe_vld_p0;
  assign pipe_data  = pipe_data_p0;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_aes_pipe_scheduler.sv
// Directed bench for aes_pipe_scheduler with a mock LAT-cycle datapath and a key-expansion model.
module tb_aes_pipe_scheduler;
  localparam int NREQ       = 4;
  localparam int LAT        = 11;
  localparam int FIFO_DEPTH = 16;
  localparam int IDW        = 2;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MASK = 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;
  localparam logic [127:0] INJ  = 128'hdeadbeef_00000000_12345678_cafef00d;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*128-1:0] req_data;
  logic [NREQ-1:0]     req_ready;
  logic                rekey;
  logic                kexp_start;
  logic                kexp_ready;
  logic [127:0]        pipe_data;
  logic                pipe_valid;
  logic [127:0]        pipe_out;
  logic                pipe_done;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [127:0]        rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic                busy;
  logic                err;

  logic                inj_done;
  logic [LAT-1:0]      dp_v;
  logic [127:0]        dp_d [LAT];
  int                  kcnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;
  int kexp_cyc = -1;
  logic [IDW-1:0] got_id [$];
  logic [127:0]   got_data [$];

  aes_pipe_scheduler #(.NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rekey(rekey), .kexp_start(kexp_start), .kexp_ready(kexp_ready),
    .pipe_data(pipe_data), .pipe_valid(pipe_valid), .pipe_out(pipe_out), .pipe_done(pipe_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mock_enc(input logic [127:0] d);
    return (d == PT) ? CT : (d ^ MASK);
  endfunction

  // Mock datapath: fixed LAT-cycle delay, reset by the same reset
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_v <= '0;
    end else begin
      dp_v <= {dp_v[LAT-2:0], pipe_valid};
      dp_d[0] <= pipe_data;
      for (int k = 1; k < LAT; k++) dp_d[k] <= dp_d[k-1];
    end
  end
  assign pipe_done = dp_v[LAT-1] | inj_done;
  assign pipe_out  = inj_done ? INJ : mock_enc(dp_d[LAT-1]);

  // Key expansion model: kexp_ready rises 5 cycles after kexp_start
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      kexp_ready <= 1'b0;
      kcnt       <= 0;
    end else if (kexp_start) begin
      kexp_ready <= 1'b0;
      kcnt       <= 4;
    end else if (kcnt != 0) begin
      kcnt <= kcnt - 1;
      if (kcnt == 1) kexp_ready <= 1'b1;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pipe_done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
    if (kexp_start) kexp_cyc <= cyc;
    if (rsp_valid && rsp_ready) begin
      got_id.push_back(rsp_id);
      got_data.push_back(rsp_data);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_req(input int i, input logic [127:0] d);
    req_data[128*i +: 128] = d;
  endtask

  task automatic bring_up();
    bit found;
    reset = 1'b1; req_valid = '0; rekey = 1'b0; inj_done = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    got_id.delete();
    got_data.delete();
    @(posedge clk); #1;
    rekey = 1'b1;
    @(posedge clk); #1;
    rekey = 1'b0;
    found = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (!busy) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL bring_up: busy=%b required 0 within 30 cycles", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    req_valid = '0; req_data = '0; rekey = 1'b0; inj_done = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || kexp_start !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: req_ready=%b kexp_start=%b required 0", req_ready, kexp_start);
    end
    checks++;
    if (pipe_valid !== 1'b0 || pipe_data !== '0) begin
      errors++; $display("FAIL reset_pipe: pipe_valid=%b pipe_data=%h required 0", pipe_valid, pipe_data);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0) begin
      errors++; $display("FAIL reset_rsp: rsp_valid=%b rsp_data=%h rsp_id=%0d required 0", rsp_valid, rsp_data, rsp_id);
    end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_status: busy=%b err=%b required 0", busy, err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || kexp_start !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b kexp_start=%b required 1/0", busy, kexp_start);
    end
  endtask

  task automatic test_single();
    int c_rekey, t;
    bit found;
    @(posedge clk); #1;
    rekey = 1'b1;
    req_valid = 4'b0100;
    set_req(2, PT);
    @(negedge clk);
    c_rekey = cyc;
    @(posedge clk); #1;
    rekey = 1'b0;
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin found = 1; break; end
    end
    t = cyc;
    checks++;
    if (!found || req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_grant: req_ready=%b required 0100", req_ready);
    end
    checks++;
    if (kexp_cyc !== c_rekey + 1) begin
      errors++; $display("FAIL kexp_timing: kexp_start cycle=%0d required %0d", kexp_cyc, c_rekey + 1);
    end
    checks++;
    if (t !== c_rekey + 7) begin
      errors++; $display("FAIL run_entry: first grant cycle=%0d required %0d", t, c_rekey + 7);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (pipe_valid !== 1'b1 || pipe_data !== PT) begin
      errors++; $display("FAIL pipe_issue: pipe_valid=%b pipe_data=%h required 1/%h", pipe_valid, pipe_data, PT);
    end
    found = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rsp_valid) begin found = 1; break; end
    end
    checks++;
    if (!found || cyc !== t + 2 + LAT) begin
      errors++; $display("FAIL rsp_latency: rsp_valid cycle=%0d required %0d", cyc, t + 2 + LAT);
    end
    checks++;
    if (rsp_id !== 2'd2 || rsp_data !== CT) begin
      errors++; $display("FAIL rsp_fips: id=%0d data=%h required 2/%h", rsp_id, rsp_data, CT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_rdy;
    logic [127:0]    exp_d;
    bring_up();
    for (int k = 0; k < 8; k++) begin
      req_valid = 4'hF;
      for (int i = 0; i < NREQ; i++) set_req(i, {96'h0, 16'(k), 16'(i)});
      @(negedge clk);
      exp_rdy = 4'(1 << (k % 4));
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_grant%0d: req_ready=%b required %b", k, req_ready, exp_rdy);
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    for (int n = 0; n < 60 && got_id.size() < 8; n++) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      exp_d = {96'h0, 16'(k), 16'(k % 4)} ^ MASK;
      checks++;
      if (k >= got_id.size()) begin
        errors++; $display("FAIL rr_rsp%0d: missing response, got %0d required 8", k, got_id.size());
      end else if (got_id[k] !== IDW'(k % 4) || got_data[k] !== exp_d) begin
        errors++; $display("FAIL rr_rsp%0d: id=%0d data=%h required %0d/%h", k, got_id[k], got_data[k], k % 4, exp_d);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int accepts, last_acc;
    logic [127:0] x;
    logic [127:0] exp_d;
    bring_up();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    accepts = 0;
    last_acc = -1;
    for (int k = 0; k < 32; k++) begin
      set_req(0, 128'(k) << 8);
      @(negedge clk);
      if (req_ready[0]) begin accepts++; last_acc = k; end
      @(posedge clk); #1;
    end
    checks++;
    if (accepts !== FIFO_DEPTH || last_acc !== FIFO_DEPTH - 1) begin
      errors++; $display("FAIL bp_accepts: accepts=%0d last=%0d required %0d/%0d", accepts, last_acc, FIFO_DEPTH, FIFO_DEPTH - 1);
    end
    checks++;
    if (err !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_status: err=%b rsp_valid=%b required 0/1", err, rsp_valid);
    end
    x = 128'hfeed_0000_0000_0000_0000_0000_0000_beef;
    set_req(0, x);
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL bp_pop_cycle: req_ready=%b required 0000", req_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL bp_resume: req_ready=%b required 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    for (int n = 0; n < 80 && got_id.size() < FIFO_DEPTH + 1; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (got_id.size() !== FIFO_DEPTH + 1) begin
      errors++; $display("FAIL bp_count: responses=%0d required %0d", got_id.size(), FIFO_DEPTH + 1);
    end else begin
      for (int k = 0; k <= FIFO_DEPTH; k++) begin
        exp_d = (k == FIFO_DEPTH) ? (x ^ MASK) : ((128'(k) << 8) ^ MASK);
        checks++;
        if (got_id[k] !== '0 || got_data[k] !== exp_d) begin
          errors++; $display("FAIL bp_rsp%0d: id=%0d data=%h required 0/%h", k, got_id[k], got_data[k], exp_d);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rekey_drain();
    int d0, s, bad;
    bit found;
    logic [127:0] y;
    logic [127:0] exp_d;
    bring_up();
    d0 = done_cnt;
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      set_req(1, 128'h100 + 128'(k));
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin
        errors++; $display("FAIL rk_issue%0d: req_ready=%b required 0010", k, req_ready);
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    rekey = 1'b1;
    @(posedge clk); #1;
    rekey = 1'b0;
    y = 128'h7777_0000_0000_0000_0000_0000_0000_0001;
    set_req(1, y);
    req_valid = 4'b0010;
    found = 0;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_ready != '0) bad++;
      if (kexp_start) begin found = 1; break; end
    end
    s = cyc;
    checks++;
    if (!found || bad !== 0) begin
      errors++; $display("FAIL rk_drain: kexp_seen=%0d issues_in_drain=%0d required 1/0", found, bad);
    end
    checks++;
    if (done_cnt - d0 !== 5 || last_done_cyc !== s - 1) begin
      errors++; $display("FAIL rk_kexp_timing: dones=%0d last_done=%0d kexp=%0d required 5/%0d", done_cnt - d0, last_done_cyc, s, s - 1);
    end
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin found = 1; break; end
    end
    checks++;
    if (!found || cyc !== s + 6 || req_ready !== 4'b0010) begin
      errors++; $display("FAIL rk_resume: cycle=%0d req_ready=%b required %0d/0010", cyc, req_ready, s + 6);
    end
    @(posedge clk); #1;
    req_valid = '0;
    for (int n = 0; n < 60 && got_id.size() < 6; n++) @(negedge clk);
    checks++;
    if (got_id.size() !== 6) begin
      errors++; $display("FAIL rk_count: responses=%0d required 6", got_id.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        exp_d = (k == 5) ? (y ^ MASK) : ((128'h100 + 128'(k)) ^ MASK);
        checks++;
        if (got_id[k] !== 2'd1 || got_data[k] !== exp_d) begin
          errors++; $display("FAIL rk_rsp%0d: id=%0d data=%h required 1/%h", k, got_id[k], got_data[k], exp_d);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_err_and_reset();
    int stray;
    bring_up();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_initial: err=%b required 0", err); end
    inj_done = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL err_set: err=%b rsp_valid=%b required 1/0", err, rsp_valid);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL err_sticky: err=%b rsp_valid=%b required 1/0", err, rsp_valid);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    set_req(3, 128'h3333);
    repeat (6) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || pipe_valid !== 1'b0 || pipe_data !== '0 || kexp_start !== 1'b0) begin
      errors++; $display("FAIL midreset_pipe: req_ready=%b pipe_valid=%b pipe_data=%h kexp_start=%b required 0", req_ready, pipe_valid, pipe_data, kexp_start);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL midreset_rsp: rsp_valid=%b rsp_data=%h rsp_id=%0d busy=%b err=%b required 0", rsp_valid, rsp_data, rsp_id, busy, err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid || err || pipe_done) stray++;
    end
    checks++;
    if (stray !== 0 || busy !== 1'b1) begin
      errors++; $display("FAIL midreset_lost: stray_events=%0d busy=%b required 0/1", stray, busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    rekey = 1'b0;
    inj_done = 1'b0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_rekey_drain();
    test_err_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_pipe_scheduler.md
# aes_pipe_scheduler

Shares one fixed-latency pipelined AES-128 encryption datapath among NREQ block requesters and sequences key expansion around it. Requesters are served round-robin. The block tracks which requester owns each in-flight block and returns ciphertext through a credit-protected response FIFO tagged with the requester ID. Re-keying is only allowed after the pipeline has fully drained. The block sits between requester ports and the pipelined encryptor plus sequential key-expansion pair.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8); IDW = max(1, clog2(NREQ))
- LAT, 11, cycles from pipe_valid high to matching pipe_done high
- FIFO_DEPTH, 16, response FIFO entries (power of 2, ≥ 2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid  in  NREQ  per-requester block valid
- req_data  in  NREQ*128  plaintext; requester i occupies bits [128*i+127:128*i]
- req_ready  out  NREQ  one-hot accept; high only for the granted requester in an issue cycle
- rekey  in  1  one-cycle request to load a new key (key value sampled by the key block at kexp_start)
- kexp_start  out  1  one-cycle pulse to key expansion
- kexp_ready  in  1  key expansion complete (round keys valid)
- pipe_data  out  128  registered plaintext to the datapath
- pipe_valid  out  1  registered data valid to the datapath
- pipe_out  in  128  ciphertext from the datapath
- pipe_done  in  1  ciphertext valid
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  128  ciphertext
- rsp_id  out  IDW  originating requester
- busy  out  1  high when state ≠ RUN or blocks are in flight
- err  out  1  sticky; pipe_done arrived with no matching tag

## Operation
- Reset values: all outputs 0. State = IDLE, RR pointer = 0, in_flight = 0, FIFO empty, tag pipe cleared.
- States:
  - IDLE: waits for rekey, then goes to KEYEXP.
  - KEYEXP: one cycle. Asserts kexp_start, then goes to KWAIT.
  - KWAIT: ignores kexp_ready on its first cycle. Afterwards, goes to RUN when kexp_ready = 1.
  - RUN: issues blocks. On rekey, goes to DRAIN.
  - DRAIN: no issue. Goes to KEYEXP when in_flight = 0.
- rekey in KEYEXP, KWAIT or DRAIN: ignored.
- Issue condition, evaluated combinationally from registered state: state = RUN, kexp_ready = 1, at least one req_valid, and in_flight + fifo_count < FIFO_DEPTH.
- A FIFO pop in the same cycle does not add credit until the next cycle.
- Arbitration: grant goes to the first i with req_valid[i], scanning ptr, ptr+1, … mod NREQ. After a grant, ptr = grant+1 mod NREQ. With no grant, ptr holds.
- On issue:
  - req_ready[grant] = 1.
  - pipe_data ← req_data[grant] and pipe_valid ← 1 on the next edge.
  - A tag {valid=1, id=grant} enters an LAT-deep shift register aligned to pipe_valid.
- in_flight is a counter: +1 on issue, −1 on pipe_done, unchanged when both occur in the same cycle.
- On pipe_done:
  - If the tag-register tail is valid, push {tail id, pipe_out} into the FIFO.
  - Otherwise, set err and discard the result.
  - The credit rule guarantees the FIFO cannot overflow. A push to a full FIFO also sets err and drops the entry.
- Response FIFO:
  - Registered outputs.
  - rsp_valid = not empty.
  - A pop occurs when rsp_valid and rsp_ready are both high.
  - Simultaneous push and pop at full or empty is legal.
  - Responses drain in every state.

## Timing
- Request handshake at edge t: pipe_valid high in cycle t+1, pipe_done at t+1+LAT, rsp_valid at t+2+LAT (13 cycles at default LAT).
- Sustained throughput: 1 block/cycle while credits are available and rsp_ready = 1.
- With rsp_ready held low: exactly FIFO_DEPTH blocks accepted, then req_ready stays 0.
- Re-key: DRAIN lasts until the last in-flight pipe_done. kexp_start follows 1 cycle later. RUN resumes on the first kexp_ready = 1 at least 2 cycles after kexp_start.
- Reset asserted mid-operation: immediate return to reset values; in-flight results are lost. The datapath is reset by the same signal.

## Test plan
- Reset, rekey, kexp_ready rises 5 cycles after kexp_start; requester 2 sends one block -> pipe_valid 1 cycle after handshake, rsp_valid 13 cycles after, rsp_id = 2, data equals the datapath output (FIPS-197 vector 00112233…eeff / 00010203…0f → 69c4e0d8…c55a).
- All four requesters hold req_valid for 8 cycles, rsp_ready = 1 -> grants 0,1,2,3,0,1,2,3, one per cycle; responses return in the same order with matching ids.
- rsp_ready = 0, requester 0 streams -> exactly 16 accepts; req_ready stays 0; no err. Raising rsp_ready restores issue one cycle after the first pop.
- rekey while 5 blocks are in flight -> no further issue; kexp_start pulses 1 cycle after the 5th pipe_done; the 5 responses are delivered; issue resumes after kexp_ready.
- pipe_done injected with an empty tag pipe -> err = 1 and stays 1; FIFO unchanged. Reset mid-stream -> all outputs 0 on the next cycle.
